reg_encodeiotx: RTL and testbench



---
 rtl/reg_encodeiotx_pkg.sv | 31 +++
 rtl/iotx_baud_gen.sv | 33 +++
 rtl/reg_encodeiotx.sv | 205 ++++++++++++++++++++
 tb/tb_reg_encodeiotx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_encodeiotx_pkg.sv
// Shared definitions for the IO decode UART transmit path: register map, cfg bits,
// FSM encoding and the Baud8 increment format common with the decode trigger receiver.
package reg_encodeiotx_pkg;

  localparam int MAX_BYTES = 8;

  localparam logic [5:0] ADDR_CFG  = 6'd59;
  localparam logic [5:0] ADDR_DATA = 6'd60;

  localparam int CFG_GO       = 0;
  localparam int CFG_ARM      = 1;
  localparam int CFG_TWO_STOP = 2;
  localparam int CFG_PAR_EN   = 3;
  localparam int CFG_PAR_EVEN = 4;
  localparam int CFG_ABORT    = 5;

  // Baud8: 16-bit phase increment, one tick8 per accumulator carry, 8 tick8 per bit
  localparam int BAUD8_W = 16;
  typedef logic [BAUD8_W-1:0] baud8_inc_t;
  localparam baud8_inc_t BAUD8_RESET_INC = 16'h0001;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } tx_state_t;

endpackage

// File: rtl/iotx_baud_gen.sv
// Baud8 phase accumulator with a divide-by-8 bit tick; a clear restarts the bit
// phase so the cycle carrying the clear already counts as the first of the bit.
module iotx_baud_gen
  import reg_encodeiotx_pkg::*;
(
  input  logic       clk,
  input  logic       reset_i,
  input  logic       clear,
  input  baud8_inc_t inc,
  output logic       tick8,
  output logic       bit_tick
);

  logic [BAUD8_W:0] acc;
  logic [2:0]       tick_cnt;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      acc      <= '0;
      tick_cnt <= '0;
    end else if (clear) begin
      acc      <= {1'b0, inc};
      tick_cnt <= '0;
    end else begin
      acc <= {1'b0, acc[BAUD8_W-1:0]} + {1'b0, inc};
      if (tick8) tick_cnt <= tick_cnt + 3'd1;
    end
  end

  assign tick8    = acc[BAUD8_W];
  assign bit_tick = tick8 && (tick_cnt == 3'd7);

endmodule

// File: rtl/reg_encodeiotx.sv
// Register-programmed UART byte-sequence transmitter (1..8 bytes per start).
// Define IODECODETX_TRIG_EN to enable the ARM bit and the trig_in start path.
module reg_encodeiotx
  import reg_encodeiotx_pkg::*;
(
  input  logic        clk,
  input  logic        reset_i,
  input  logic [5:0]  reg_address,
  input  logic [15:0] reg_bytecnt,
  input  logic [7:0]  reg_datai,
  output logic [7:0]  reg_datao,
  input  logic [15:0] reg_size,
  input  logic        reg_read,
  input  logic        reg_write,
  input  logic        reg_addrvalid,
  output logic        reg_stream,
  input  logic [5:0]  reg_hypaddress,
  output logic [15:0] reg_hyplen,
  input  logic        trig_in,
  output logic        txd,
  output logic        tx_busy,
  output logic        tx_done
);

  tx_state_t  state, state_next;
  logic       two_stop, par_en, par_even, arm, done_sticky;
  logic [3:0] n_cfg, n_eff;
  baud8_inc_t inc;
  logic [7:0] data_mem [MAX_BYTES];
  logic [7:0] shift;
  logic       par_bit;
  logic [2:0] idx, bit_cnt, sel;
  logic       in_range, cfg_wr, data_wr, go_wr, abort_wr, rate_wr;
  logic       abort_req, start_req, trig_start;
  logic       baud_clear, tick8, bit_tick, done_next, more_bytes, stop_last;
  logic [7:0] rd_mux;
  logic       unused_ok;

  assign sel        = reg_bytecnt[2:0];
  assign in_range   = (reg_bytecnt[15:3] == '0);
  assign cfg_wr     = reg_write && in_range && (reg_address == ADDR_CFG);
  assign data_wr    = reg_write && in_range && (reg_address == ADDR_DATA);
  assign go_wr      = cfg_wr && (sel == 3'd0) && reg_datai[CFG_GO];
  assign abort_wr   = cfg_wr && (sel == 3'd0) && reg_datai[CFG_ABORT];
  assign rate_wr    = cfg_wr && (sel >= 3'd1) && (sel <= 3'd3);
  // Changing count or baud mid-sequence would corrupt the frame, so it aborts
  assign abort_req  = tx_busy && (abort_wr || rate_wr);
  assign start_req  = go_wr || trig_start;
  assign n_eff      = (n_cfg > 4'd8) ? 4'd8 : n_cfg;
  assign more_bytes = ({1'b0, idx} + 4'd1) < n_eff;
  assign stop_last  = !two_stop || (bit_cnt == 3'd1);
  assign tx_busy    = (state != ST_IDLE);
  assign reg_stream = 1'b0;
  assign reg_hyplen = ((reg_hypaddress == ADDR_CFG) || (reg_hypaddress == ADDR_DATA)) ? 16'd8 : 16'd0;
  assign unused_ok  = ^{reg_size, reg_addrvalid, tick8};

`ifdef IODECODETX_TRIG_EN
  logic [2:0] trig_sync;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      trig_sync <= '0;
      arm       <= 1'b0;
    end else begin
      trig_sync <= {trig_sync[1:0], trig_in};
      if (cfg_wr && (sel == 3'd0)) arm <= reg_datai[CFG_ARM];
    end
  end

  assign trig_start = arm && trig_sync[1] && !trig_sync[2];
`else
  logic unused_trig;
  assign unused_trig = trig_in;
  assign arm         = 1'b0;
  assign trig_start  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset_i) begin
      two_stop <= 1'b0;
      par_en   <= 1'b0;
      par_even <= 1'b0;
      n_cfg    <= '0;
      inc      <= BAUD8_RESET_INC;
      for (int i = 0; i < MAX_BYTES; i++) data_mem[i] <= '0;
    end else begin
      if (cfg_wr) begin
        case (sel)
          3'd0: begin
            two_stop <= reg_datai[CFG_TWO_STOP];
            par_en   <= reg_datai[CFG_PAR_EN];
            par_even <= reg_datai[CFG_PAR_EVEN];
          end
          3'd1: n_cfg      <= reg_datai[3:0];
          3'd2: inc[7:0]   <= reg_datai;
          3'd3: inc[15:8]  <= reg_datai;
          default: ;
        endcase
      end
      if (data_wr) data_mem[sel] <= reg_datai;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (in_range && (reg_address == ADDR_CFG)) begin
      case (sel)
        3'd0:    rd_mux = {2'b00, par_even, par_en, two_stop, arm, 1'b0};
        3'd1:    rd_mux = {4'b0000, n_cfg};
        3'd2:    rd_mux = inc[7:0];
        3'd3:    rd_mux = inc[15:8];
        3'd4:    rd_mux = {6'b0, done_sticky, tx_busy};
        default: rd_mux = '0;
      endcase
    end else if (in_range && (reg_address == ADDR_DATA)) begin
      rd_mux = data_mem[sel];
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      reg_datao   <= '0;
      done_sticky <= 1'b0;
    end else begin
      if (reg_read) reg_datao <= rd_mux;
      if (done_next) done_sticky <= 1'b1;
      else if (go_wr) done_sticky <= 1'b0;
    end
  end

  iotx_baud_gen u_baud (
    .clk      (clk),
    .reset_i  (reset_i),
    .clear    (baud_clear),
    .inc      (inc),
    .tick8    (tick8),
    .bit_tick (bit_tick)
  );

  // The baud phase is cleared on entry to LOAD so LOAD is the first cycle of the start bit
  always_comb begin
    state_next = state;
    baud_clear = 1'b0;
    done_next  = 1'b0;
    case (state)
      ST_IDLE:   if (start_req && (n_eff != 4'd0)) begin
                   state_next = ST_LOAD;
                   baud_clear = 1'b1;
                 end
      ST_LOAD:   state_next = ST_START;
      ST_START:  if (bit_tick) state_next = ST_DATA;
      ST_DATA:   if (bit_tick && (bit_cnt == 3'd7)) state_next = par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_tick) state_next = ST_STOP;
      ST_STOP:   if (bit_tick && stop_last) begin
                   if (more_bytes) begin
                     state_next = ST_LOAD;
                     baud_clear = 1'b1;
                   end else begin
                     state_next = ST_IDLE;
                     done_next  = 1'b1;
                   end
                 end
      default:   state_next = ST_IDLE;
    endcase
    if (abort_req) begin
      state_next = ST_IDLE;
      baud_clear = 1'b0;
      done_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state   <= ST_IDLE;
      idx     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_next;
      tx_done <= done_next;
      if (state_next != state) bit_cnt <= '0;
      else if (bit_tick) bit_cnt <= bit_cnt + 3'd1;
      if (state == ST_IDLE) idx <= '0;
      else if ((state == ST_STOP) && (state_next == ST_LOAD)) idx <= idx + 3'd1;
      if (state == ST_LOAD) begin
        shift   <= data_mem[idx];
        par_bit <= (^data_mem[idx]) ^ ~par_even;
      end else if ((state == ST_DATA) && bit_tick) begin
        shift <= {1'b0, shift[7:1]};
      end
    end
  end

  always_comb begin
    case (state)
      ST_LOAD, ST_START: txd = 1'b0;
      ST_DATA:           txd = shift[0];
      ST_PARITY:         txd = par_bit;
      default:           txd = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_reg_encodeiotx.sv
// Directed self-checking bench for reg_encodeiotx: frames are sampled mid-bit at a
// 16-clock bit period (inc=0x8000); IODECODETX_TRIG_EN selects the trigger checks.
module tb_reg_encodeiotx;

  localparam logic [5:0] CFG  = 6'd59;
  localparam logic [5:0] DATA = 6'd60;

  logic        clk;
  logic        reset_i;
  logic [5:0]  reg_address;
  logic [15:0] reg_bytecnt;
  logic [7:0]  reg_datai;
  logic [7:0]  reg_datao;
  logic [15:0] reg_size;
  logic        reg_read;
  logic        reg_write;
  logic        reg_addrvalid;
  logic        reg_stream;
  logic [5:0]  reg_hypaddress;
  logic [15:0] reg_hyplen;
  logic        trig_in;
  logic        txd;
  logic        tx_busy;
  logic        tx_done;

  int check_count = 0;
  int error_count = 0;
  int busy_count  = 0;
  int done_count  = 0;

  reg_encodeiotx dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .reg_address    (reg_address),
    .reg_bytecnt    (reg_bytecnt),
    .reg_datai      (reg_datai),
    .reg_datao      (reg_datao),
    .reg_size       (reg_size),
    .reg_read       (reg_read),
    .reg_write      (reg_write),
    .reg_addrvalid  (reg_addrvalid),
    .reg_stream     (reg_stream),
    .reg_hypaddress (reg_hypaddress),
    .reg_hyplen     (reg_hyplen),
    .trig_in        (trig_in),
    .txd            (txd),
    .tx_busy        (tx_busy),
    .tx_done        (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running totals of busy cycles and done pulses, read as deltas around each sequence
  always @(negedge clk) begin
    if (tx_busy) busy_count++;
    if (tx_done) done_count++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyWrite(input logic [5:0] addr, input logic [15:0] idx, input logic [7:0] val);
    @(negedge clk);
    reg_address = addr;
    reg_bytecnt = idx;
    reg_datai   = val;
    reg_write   = 1'b1;
    @(negedge clk);
    reg_write   = 1'b0;
  endtask

  task automatic applyRead(input logic [5:0] addr, input logic [15:0] idx, output logic [7:0] val);
    @(negedge clk);
    reg_address = addr;
    reg_bytecnt = idx;
    reg_read    = 1'b1;
    @(negedge clk);
    reg_read    = 1'b0;
    val         = reg_datao;
  endtask

  // Called at the negedge of the first start-bit cycle; returns 16*nbits cycles later
  task automatic expectFrame(input string tag, input logic [7:0] b, input logic par_en,
                             input logic par_bit, input logic two_stop);
    logic [11:0] frame;
    int nb;
    frame    = 12'hFFF;
    frame[0] = 1'b0;
    frame[8:1] = b;
    if (par_en) frame[9] = par_bit;
    nb = 10 + (par_en ? 1 : 0) + (two_stop ? 1 : 0);
    repeat (8) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      checkOutput($sformatf("%s_bit%0d", tag, i), txd, frame[i]);
      if (i < nb - 1) repeat (16) @(negedge clk);
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rd;
    int b0, d0, lat;

    reset_i = 1'b1; reg_address = '0; reg_bytecnt = '0; reg_datai = '0;
    reg_size = 16'd1; reg_read = 1'b0; reg_write = 1'b0; reg_addrvalid = 1'b1;
    reg_hypaddress = '0; trig_in = 1'b0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);

    checkOutput("rst_txd", txd, 1);
    checkOutput("rst_busy", tx_busy, 0);
    checkOutput("rst_done", tx_done, 0);
    checkOutput("rst_datao", reg_datao, 0);
    checkOutput("stream", reg_stream, 0);
    applyRead(CFG, 2, rd);  checkOutput("rst_inc_lo", rd, 8'h01);
    applyRead(CFG, 3, rd);  checkOutput("rst_inc_hi", rd, 8'h00);
    applyRead(CFG, 1, rd);  checkOutput("rst_count", rd, 8'h00);

    reg_hypaddress = 6'd59; #1 checkOutput("hyplen_cfg", reg_hyplen, 16'd8);
    reg_hypaddress = 6'd60; #1 checkOutput("hyplen_data", reg_hyplen, 16'd8);
    reg_hypaddress = 6'd10; #1 checkOutput("hyplen_other", reg_hyplen, 16'd0);

    // Single byte 0x55 at 16 clocks per bit
    applyWrite(CFG, 2, 8'h00);
    applyWrite(CFG, 3, 8'h80);
    applyWrite(CFG, 1, 8'h01);
    applyWrite(DATA, 0, 8'h55);
    applyRead(DATA, 0, rd); checkOutput("data0_rb", rd, 8'h55);
    applyWrite(CFG, 0, 8'h01);
    checkOutput("t1_busy", tx_busy, 1);
    expectFrame("t1", 8'h55, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_done_pulse", tx_done, 1);
    checkOutput("t1_idle", tx_busy, 0);
    @(negedge clk);
    checkOutput("t1_done_clear", tx_done, 0);
    applyRead(CFG, 0, rd); checkOutput("go_reads0", rd, 8'h00);
    applyRead(CFG, 4, rd); checkOutput("t1_status", rd, 8'h02);

    // Three bytes, even parity, two stop bits
    applyWrite(CFG, 1, 8'h03);
    applyWrite(DATA, 0, 8'h01);
    applyWrite(DATA, 1, 8'h02);
    applyWrite(DATA, 2, 8'h03);
    repeat (3) @(negedge clk);
    b0 = busy_count; d0 = done_count;
    applyWrite(CFG, 0, 8'h1D);
    expectFrame("t2a", 8'h01, 1'b1, 1'b1, 1'b1);
    expectFrame("t2b", 8'h02, 1'b1, 1'b1, 1'b1);
    expectFrame("t2c", 8'h03, 1'b1, 1'b0, 1'b1);
    checkOutput("t2_done_pulse", tx_done, 1);
    repeat (3) @(negedge clk);
    checkOutput("t2_busy_cycles", busy_count - b0, 576);
    checkOutput("t2_done_count", done_count - d0, 1);
    applyRead(CFG, 0, rd); checkOutput("t2_cfg_rb", rd, 8'h1C);

    // Abort in the middle of byte 1 data bits
    applyWrite(CFG, 1, 8'h04);
    applyWrite(DATA, 0, 8'hA5);
    applyWrite(DATA, 1, 8'h3C);
    applyWrite(DATA, 2, 8'h0F);
    applyWrite(DATA, 3, 8'hF0);
    repeat (3) @(negedge clk);
    d0 = done_count;
    applyWrite(CFG, 0, 8'h01);
    repeat (200) @(negedge clk);
    checkOutput("t3_pre_txd", txd, 0);
    checkOutput("t3_pre_busy", tx_busy, 1);
    applyWrite(CFG, 0, 8'h20);
    checkOutput("t3_txd", txd, 1);
    checkOutput("t3_busy", tx_busy, 0);
    repeat (300) @(negedge clk);
    checkOutput("t3_txd_idle", txd, 1);
    checkOutput("t3_no_done", done_count - d0, 0);
    applyRead(CFG, 4, rd); checkOutput("t3_status", rd, 8'h00);

    // GO while busy is ignored, GO after done retransmits
    applyWrite(CFG, 1, 8'h01);
    applyWrite(DATA, 0, 8'h55);
    repeat (3) @(negedge clk);
    d0 = done_count;
    applyWrite(CFG, 0, 8'h01);
    repeat (40) @(negedge clk);
    applyWrite(CFG, 0, 8'h01);
    repeat (117) @(negedge clk);
    checkOutput("t4_busy159", tx_busy, 1);
    checkOutput("t4_nodone159", tx_done, 0);
    @(negedge clk);
    checkOutput("t4_done160", tx_done, 1);
    checkOutput("t4_idle160", tx_busy, 0);
    repeat (5) @(negedge clk);
    applyWrite(CFG, 0, 8'h01);
    expectFrame("t4r", 8'h55, 1'b0, 1'b0, 1'b0);
    checkOutput("t4r_done", tx_done, 1);
    repeat (3) @(negedge clk);
    checkOutput("t4_done_count", done_count - d0, 2);

    // Count 15 clamps to 8 bytes of 160 clocks each
    applyWrite(CFG, 1, 8'h0F);
    applyRead(CFG, 1, rd); checkOutput("clamp_rb", rd, 8'h0F);
    repeat (3) @(negedge clk);
    b0 = busy_count; d0 = done_count;
    applyWrite(CFG, 0, 8'h01);
    repeat (1290) @(negedge clk);
    checkOutput("clamp_busy_cycles", busy_count - b0, 1280);
    checkOutput("clamp_done", done_count - d0, 1);

    // Count 0 never starts
    applyWrite(CFG, 1, 8'h00);
    applyWrite(CFG, 0, 8'h01);
    repeat (5) @(negedge clk);
    checkOutput("n0_busy", tx_busy, 0);

    // inc=0 freezes in the start bit until ABORT
    applyWrite(CFG, 1, 8'h01);
    applyWrite(CFG, 3, 8'h00);
    applyWrite(CFG, 0, 8'h01);
    repeat (100) @(negedge clk);
    checkOutput("inc0_busy", tx_busy, 1);
    checkOutput("inc0_txd", txd, 0);
    applyWrite(CFG, 0, 8'h20);
    checkOutput("inc0_abort_busy", tx_busy, 0);
    checkOutput("inc0_abort_txd", txd, 1);
    applyWrite(CFG, 3, 8'h80);

    // External trigger start
    applyWrite(DATA, 0, 8'h55);
    applyWrite(CFG, 0, 8'h02);
    applyRead(CFG, 0, rd);
    @(negedge clk);
    trig_in = 1'b1;
    lat = 0;
    while (lat < 20 && txd !== 1'b0) begin
      @(negedge clk);
      lat++;
    end
`ifdef IODECODETX_TRIG_EN
    checkOutput("arm_rb", rd, 8'h02);
    checkOutput("trig_latency_ok", (lat >= 1 && lat <= 4), 1);
    checkOutput("trig_busy", tx_busy, 1);
    repeat (170) @(negedge clk);
    checkOutput("trig_finished", tx_busy, 0);
`else
    checkOutput("arm_rb", rd, 8'h00);
    checkOutput("trig_ignored_busy", tx_busy, 0);
    checkOutput("trig_ignored_txd", txd, 1);
`endif
    trig_in = 1'b0;
    applyWrite(CFG, 0, 8'h00);

    // Synchronous reset mid-frame
    applyWrite(CFG, 0, 8'h01);
    repeat (30) @(negedge clk);
    checkOutput("mid_busy", tx_busy, 1);
    reset_i = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_txd", txd, 1);
    checkOutput("mid_rst_busy", tx_busy, 0);
    checkOutput("mid_rst_done", tx_done, 0);
    reset_i = 1'b0;
    applyRead(CFG, 2, rd); checkOutput("mid_rst_inc", rd, 8'h01);
    applyRead(DATA, 0, rd); checkOutput("mid_rst_data", rd, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
